// File: rtl/wrr_packet_arbiter_pkg.sv
// Shared defaults and types for the IMEM write-back packet arbiter.
package wrr_packet_arbiter_pkg;

  localparam int unsigned NUM_EDGE_PE         = 4;
  localparam int unsigned WB_ARB_NUM_REQS     = NUM_EDGE_PE + 1;
  localparam int unsigned WB_ARB_WEIGHT_W     = 3;
  localparam int unsigned WB_ARB_STARVE_LIMIT = 64;

  typedef logic [WB_ARB_NUM_REQS-1:0][WB_ARB_WEIGHT_W-1:0] wb_weights_t;

  typedef enum logic [0:0] {StIdle, StBusy} arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wrr_select.sv
// Find-first-set starting at a rotating pointer, with wrap-around.
module wrr_select
  import wrr_packet_arbiter_pkg::*;
#(
  parameter int unsigned NumReqs = WB_ARB_NUM_REQS
) (
  input  logic [NumReqs-1:0]              cand_i,
  input  logic [idx_width(NumReqs)-1:0]   ptr_i,
  output logic [NumReqs-1:0]              grant_o,
  output logic                            found_o
);

  localparam int unsigned IdxW = idx_width(NumReqs);

  always_comb begin
    int unsigned      pos;
    logic [IdxW-1:0]  sel;
    grant_o = '0;
    found_o = 1'b0;
    for (int unsigned k = 0; k < NumReqs; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= NumReqs) pos = pos - NumReqs;
      sel = IdxW'(pos);
      if (!found_o && cand_i[sel]) begin
        grant_o[sel] = 1'b1;
        found_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin packet arbiter with packet locking, a priority class
// and a starvation guard; grants are registered and switch without bubbles.
module wrr_packet_arbiter
  import wrr_packet_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS     = WB_ARB_NUM_REQS,
  parameter int unsigned WEIGHT_W     = WB_ARB_WEIGHT_W,
  parameter int unsigned STARVE_LIMIT = WB_ARB_STARVE_LIMIT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQS-1:0]                reqs,
  input  logic [NUM_REQS-1:0]                eop,
  input  logic [NUM_REQS-1:0]                more,
  input  logic [NUM_REQS-1:0][WEIGHT_W-1:0]  weights,
  input  logic [NUM_REQS-1:0]                prio_mask,
  output logic [NUM_REQS-1:0]                grants,
  output logic                               grant_valid,
  output logic [idx_width(NUM_REQS)-1:0]     grant_idx,
  output logic                               starve_any
);

  localparam int unsigned IdxW = idx_width(NUM_REQS);
  localparam int unsigned WcW  = $clog2(STARVE_LIMIT + 1);

  typedef logic [IdxW-1:0] idx_t;

  arb_state_e                         st_q, st_d;
  logic [NUM_REQS-1:0]                grants_q, grants_d;
  idx_t                               idx_q, idx_d, ptr_q, ptr_d, win_idx;
  logic [WEIGHT_W-1:0]                cr_q, cr_d, win_weight;
  logic [NUM_REQS-1:0][WcW-1:0]       wc_q, wc_d;
  logic [NUM_REQS-1:0]                starving, cand;
  logic [NUM_REQS-1:0]                starve_oh, prio_oh, norm_oh, win_oh;
  logic                               starve_found, prio_found, norm_found;
  logic                               do_arb, keep_turn, starve_other;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      starving[i] = (wc_q[i] == WcW'(STARVE_LIMIT));
      if (!reqs[i] || grants_q[i]) wc_d[i] = '0;
      else if (starving[i])        wc_d[i] = wc_q[i];
      else                         wc_d[i] = wc_q[i] + WcW'(1);
    end
  end

  assign starve_other = |(starving & ~grants_q);

  // Candidate set; at a packet boundary the holder competes only if it has more.
  always_comb begin
    cand      = reqs;
    do_arb    = 1'b0;
    keep_turn = 1'b0;
    case (st_q)
      StBusy: begin
        if (!reqs[idx_q]) begin
          do_arb = 1'b1;
        end else if (eop[idx_q]) begin
          if (more[idx_q] && (cr_q != '0) && !starve_other) begin
            keep_turn = 1'b1;
          end else begin
            cand[idx_q] = more[idx_q];
            do_arb      = 1'b1;
          end
        end
      end
      default: do_arb = 1'b1;
    endcase
  end

  // In BUSY the pointer sits at holder+1, so the holder is searched last.
  wrr_select #(.NumReqs(NUM_REQS)) u_sel_starve (
    .cand_i  (cand & starving),
    .ptr_i   (ptr_q),
    .grant_o (starve_oh),
    .found_o (starve_found)
  );

  wrr_select #(.NumReqs(NUM_REQS)) u_sel_prio (
    .cand_i  (cand & prio_mask),
    .ptr_i   (ptr_q),
    .grant_o (prio_oh),
    .found_o (prio_found)
  );

  wrr_select #(.NumReqs(NUM_REQS)) u_sel_norm (
    .cand_i  (cand),
    .ptr_i   (ptr_q),
    .grant_o (norm_oh),
    .found_o (norm_found)
  );

  always_comb begin
    if (starve_found)    win_oh = starve_oh;
    else if (prio_found) win_oh = prio_oh;
    else                 win_oh = norm_oh;
    win_idx = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (win_oh[i]) win_idx = idx_t'(i);
    end
    win_weight = weights[win_idx];
    if (win_weight == '0) win_weight = WEIGHT_W'(1);
  end

  always_comb begin
    st_d     = st_q;
    grants_d = grants_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    cr_d     = cr_q;
    if (keep_turn) cr_d = cr_q - WEIGHT_W'(1);
    if (do_arb) begin
      if (norm_found) begin
        st_d     = StBusy;
        grants_d = win_oh;
        idx_d    = win_idx;
        cr_d     = win_weight - WEIGHT_W'(1);
        ptr_d    = (win_idx == idx_t'(NUM_REQS - 1)) ? '0 : win_idx + idx_t'(1);
      end else begin
        st_d     = StIdle;
        grants_d = '0;
        idx_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= StIdle;
      grants_q <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      cr_q     <= '0;
      wc_q     <= '0;
    end else begin
      st_q     <= st_d;
      grants_q <= grants_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      cr_q     <= cr_d;
      wc_q     <= wc_d;
    end
  end

  assign grants      = grants_q;
  assign grant_valid = |grants_q;
  assign grant_idx   = idx_q;
  assign starve_any  = |starving;

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and a
// randomized run against a behavioural reference model.
module tb_wrr_packet_arbiter;

  localparam int NR  = 5;
  localparam int WW  = 3;
  localparam int LIM = 8;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [NR-1:0]          reqs, eop, more, prio_mask;
  logic [NR-1:0][WW-1:0]  weights;
  logic [NR-1:0]          grants;
  logic                   grant_valid;
  logic [2:0]             grant_idx;
  logic                   starve_any;

  int n_tests = 0;
  int n_fail  = 0;

  wrr_packet_arbiter #(
    .NUM_REQS     (NR),
    .WEIGHT_W     (WW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .reqs        (reqs),
    .eop         (eop),
    .more        (more),
    .weights     (weights),
    .prio_mask   (prio_mask),
    .grants      (grants),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .starve_any  (starve_any)
  );

  always #5 clk = ~clk;

  // Reference model: holder index (-1 = none), pointer, credit, wait counts.
  int m_holder, m_ptr, m_cr;
  int m_wc[NR];

  typedef struct {
    bit            rst;
    logic [WW-1:0] w2;
    logic [NR-1:0] reqs;
    logic [NR-1:0] eop;
    logic [NR-1:0] more;
    logic [NR-1:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int find_from(input logic [NR-1:0] c, input int start);
    for (int k = 0; k < NR; k++) begin
      int i = (start + k) % NR;
      if (c[i]) return i;
    end
    return -1;
  endfunction

  function automatic int choose(input logic [NR-1:0] c, input int start);
    logic [NR-1:0] starv;
    logic [NR-1:0] pr;
    for (int i = 0; i < NR; i++) starv[i] = c[i] && (m_wc[i] == LIM);
    pr = c & prio_mask;
    if (starv != 0) return find_from(starv, start);
    if (pr != 0)    return find_from(pr, start);
    return find_from(c, start);
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_ptr    = 0;
    m_cr     = 0;
    for (int i = 0; i < NR; i++) m_wc[i] = 0;
  endtask

  task automatic model_step();
    int            nwc[NR];
    logic [NR-1:0] c;
    bit            arb = 1'b0;
    bit            other_starving = 1'b0;
    int            start = m_ptr;
    for (int i = 0; i < NR; i++)
      nwc[i] = (!reqs[i] || i == m_holder) ? 0 : ((m_wc[i] < LIM) ? m_wc[i] + 1 : LIM);
    c = reqs;
    if (m_holder < 0 || !reqs[m_holder]) begin
      arb = 1'b1;
    end else if (eop[m_holder]) begin
      for (int i = 0; i < NR; i++)
        if (i != m_holder && m_wc[i] == LIM) other_starving = 1'b1;
      if (more[m_holder] && m_cr > 0 && !other_starving) begin
        m_cr--;
      end else begin
        arb         = 1'b1;
        c[m_holder] = more[m_holder];
        start       = (m_holder + 1) % NR;
      end
    end
    if (arb) begin
      int w = choose(c, start);
      if (w >= 0) begin
        m_holder = w;
        m_cr     = (weights[w] == 0) ? 0 : int'(weights[w]) - 1;
        m_ptr    = (w + 1) % NR;
      end else begin
        m_holder = -1;
      end
    end
    m_wc = nwc;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #3;
    reset = 1'b0;
  endtask

  task automatic weights_ones();
    for (int i = 0; i < NR; i++) weights[i] = WW'(1);
  endtask

  initial begin
    logic [NR-1:0] exp_g;
    logic          exp_starve;

    reqs = '0; eop = '0; more = '0; prio_mask = '0;
    weights_ones();

    // Plain RR over all five, then weight 3 on requester 2 against requester 3.
    vecs[0]  = '{1'b1, 3'd1, 5'b11111, 5'b11111, 5'b11111, 5'b00001};
    vecs[1]  = '{1'b0, 3'd1, 5'b11111, 5'b11111, 5'b11111, 5'b00010};
    vecs[2]  = '{1'b0, 3'd1, 5'b11111, 5'b11111, 5'b11111, 5'b00100};
    vecs[3]  = '{1'b0, 3'd1, 5'b11111, 5'b11111, 5'b11111, 5'b01000};
    vecs[4]  = '{1'b0, 3'd1, 5'b11111, 5'b11111, 5'b11111, 5'b10000};
    vecs[5]  = '{1'b0, 3'd1, 5'b11111, 5'b11111, 5'b11111, 5'b00001};
    vecs[6]  = '{1'b1, 3'd3, 5'b01100, 5'b11111, 5'b11111, 5'b00100};
    vecs[7]  = '{1'b0, 3'd3, 5'b01100, 5'b11111, 5'b11111, 5'b00100};
    vecs[8]  = '{1'b0, 3'd3, 5'b01100, 5'b11111, 5'b11111, 5'b00100};
    vecs[9]  = '{1'b0, 3'd3, 5'b01100, 5'b11111, 5'b11111, 5'b01000};
    vecs[10] = '{1'b0, 3'd3, 5'b01100, 5'b11111, 5'b11111, 5'b00100};
    vecs[11] = '{1'b0, 3'd3, 5'b01100, 5'b11111, 5'b11111, 5'b00100};
    vecs[12] = '{1'b0, 3'd3, 5'b01100, 5'b11111, 5'b11111, 5'b00100};
    vecs[13] = '{1'b0, 3'd3, 5'b01100, 5'b11111, 5'b11111, 5'b01000};

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) do_reset();
      weights_ones();
      weights[2] = vecs[i].w2;
      reqs = vecs[i].reqs;
      eop  = vecs[i].eop;
      more = vecs[i].more;
      tick();
      check($sformatf("vec%0d_grants", i), 32'(grants), 32'(vecs[i].exp));
    end

    // Asynchronous reset in the middle of a packet held by requester 2.
    weights_ones();
    do_reset();
    reqs = 5'b00100; eop = '0; more = '0;
    tick();
    check("rst_first_grant", 32'(grants), 32'(5'b00100));
    tick();
    tick();
    check("rst_hold", 32'(grants), 32'(5'b00100));
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_async_grants", 32'(grants), 32'd0);
    check("rst_async_valid", 32'(grant_valid), 32'd0);
    check("rst_async_idx", 32'(grant_idx), 32'd0);
    check("rst_async_starve", 32'(starve_any), 32'd0);
    #2;
    reset = 1'b0;
    tick();
    check("rst_regrant", 32'(grants), 32'(5'b00100));

    // Packet lock: a prio request from 0 must not pre-empt a 10-beat packet.
    do_reset();
    reqs = 5'b00010; eop = '0; more = '0; prio_mask = '0;
    tick();
    reqs = 5'b00011; prio_mask = 5'b00001;
    for (int b = 1; b <= 10; b++) begin
      check($sformatf("lock_beat%0d", b), 32'(grants), 32'(5'b00010));
      if (b == 10) eop = 5'b00011;
      tick();
    end
    check("lock_handoff", 32'(grants), 32'(5'b00001));
    eop = '0;

    // Starvation: prio pair 0/1 ping-pongs until requester 4 saturates.
    do_reset();
    prio_mask = 5'b00011; reqs = 5'b10011; eop = 5'b11111; more = 5'b11111;
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (t <= 8) check($sformatf("starve_pp%0d", t), 32'(grants),
                        (t % 2 == 1) ? 32'(5'b00001) : 32'(5'b00010));
      if (t == 7) check("starve_any_pre", 32'(starve_any), 32'd0);
      if (t == 8) check("starve_any_set", 32'(starve_any), 32'd1);
    end
    check("starve_forced", 32'(grants), 32'(5'b10000));

    // Abort with nobody else requesting, then a fresh request from idle.
    do_reset();
    prio_mask = '0; reqs = 5'b01000; eop = '0; more = '0;
    tick();
    check("abort_grant", 32'(grants), 32'(5'b01000));
    tick();
    check("abort_hold", 32'(grants), 32'(5'b01000));
    reqs = '0;
    tick();
    check("abort_drop", 32'(grants), 32'd0);
    check("abort_valid", 32'(grant_valid), 32'd0);
    reqs = 5'b00010;
    tick();
    check("abort_regrant", 32'(grants), 32'(5'b00010));
    check("abort_idx", 32'(grant_idx), 32'd1);

    // Randomized run against the reference model.
    do_reset();
    reqs = '0;
    for (int i = 0; i < NR; i++) weights[i] = WW'($urandom);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NR; i++)
        if ($urandom_range(7) == 0) reqs[i] = ~reqs[i];
      eop  = NR'($urandom) & NR'($urandom);
      more = NR'($urandom);
      if ($urandom_range(31) == 0) prio_mask = NR'($urandom);
      if ($urandom_range(15) == 0) weights[$urandom_range(NR - 1)] = WW'($urandom);
      tick();
      exp_g = (m_holder >= 0) ? NR'(1 << m_holder) : '0;
      exp_starve = 1'b0;
      for (int i = 0; i < NR; i++) if (m_wc[i] == LIM) exp_starve = 1'b1;
      check($sformatf("rnd%0d_grants", k), 32'(grants), 32'(exp_g));
      check($sformatf("rnd%0d_idx", k), 32'(grant_idx), (m_holder >= 0) ? m_holder : 0);
      check($sformatf("rnd%0d_valid", k), 32'(grant_valid), 32'(m_holder >= 0));
      check($sformatf("rnd%0d_starve", k), 32'(starve_any), 32'(exp_starve));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
